wb_reg_slave: RTL and testbench
===============================

WB_REG_SLAVE -- requirements
Module: wb_reg_slave

Interface
REQ-001 Parameter REG_WIDTH, default 32, data bus width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 5, word-address width.
REQ-003 Parameter NUM_REGS, default 32, implemented registers; SHALL be <= 2**ADDR_WIDTH.
REQ-004 Parameter WAIT_STATES, default 0, extra cycles inserted before the response; range 0..15.
REQ-005 Parameter ID_VALUE, default 32'h5742_0001, read-only contents of register 0.
REQ-006 clk  input  1  single clock; all logic on posedge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 wb_adr_i  input  ADDR_WIDTH  word address.
REQ-009 wb_dat_i  input  REG_WIDTH  write data.
REQ-010 wb_dat_o  output  REG_WIDTH  read data.
REQ-011 sel_i  input  REG_WIDTH/8  byte-lane enables.
REQ-012 we_i, stb_i, cyc_i  input  1 each  write enable, strobe, cycle.
REQ-013 ack_o  output  1  normal termination.
REQ-014 err_o  output  1  error termination.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-016 In IDLE, cyc_i&stb_i sampled high at edge N SHALL capture adr, dat, sel and we, then go to WAIT (WAIT_STATES>0) or RESP (WAIT_STATES=0).
REQ-017 WAIT SHALL hold a down-counter loaded with WAIT_STATES-1 and go to RESP when the counter reaches 0.
REQ-018 ack_o or err_o SHALL be high for exactly one cycle, following edge N+1+WAIT_STATES; RESP SHALL always return to IDLE.
REQ-019 ack_o and err_o SHALL never be high together.
REQ-020 A captured address >= NUM_REGS SHALL produce err_o, no register change and wb_dat_o = 0.
REQ-021 A write SHALL commit at the edge that asserts ack_o, updating only the bytes whose sel bit is 1.
REQ-022 sel = 0 on a write SHALL still ack and leave all registers unchanged.
REQ-023 Register 0 SHALL read ID_VALUE; writes to it SHALL ack and be ignored.
REQ-024 A read SHALL drive the addressed register on wb_dat_o while ack_o is high, ignoring sel; wb_dat_o SHALL be 0 at all other times.
REQ-025 cyc_i low sampled in WAIT SHALL abort to IDLE with no response and no write.
REQ-026 cyc_i low sampled in RESP SHALL NOT suppress the response already driven.
REQ-027 stb_i still high in the first IDLE cycle after RESP SHALL be accepted as a new request; throughput is one transfer per 2+WAIT_STATES cycles.

Reset
REQ-028 rst_n low SHALL immediately set state to IDLE, ack_o = 0, err_o = 0, wb_dat_o = 0, wait counter = 0 and registers 1..NUM_REGS-1 to 0.
REQ-029 Reset asserted mid-transaction SHALL drop the transaction with no write and no response.
REQ-030 The first request SHALL be accepted no earlier than the first posedge after rst_n deasserts.

Structure
REQ-031 Package wb_pkg SHALL hold the state enum (IDLE/WAIT/RESP), the default ID_VALUE and the WAIT_STATES maximum.
REQ-032 Register storage with byte-enable writes SHALL be a sub-module named wb_regfile; the FSM, counter and response logic SHALL stay in wb_reg_slave.

Verification
REQ-033 WAIT_STATES=0: write 32'hDEADBEEF to addr 3 with sel=4'hF, then read addr 3 -> each ack_o is 1 cycle after acceptance and the read returns 32'hDEADBEEF.
REQ-034 WAIT_STATES=3: read addr 0 -> ack_o follows edge N+4 and wb_dat_o = 32'h5742_0001; a write of 0 to addr 0 acks and the read-back still returns ID.
REQ-035 Write 32'h11223344 to addr 5 with sel=4'hF, then 32'hAABBCCDD with sel=4'b0101, then read -> 32'h11BB33DD.
REQ-036 With NUM_REGS=16, write to addr 20 -> err_o for 1 cycle, no ack_o, no register changed.
REQ-037 WAIT_STATES=4, cyc_i dropped 2 cycles after acceptance -> no ack_o/err_o and the target register unchanged; rst_n pulsed mid-wait -> all outputs 0 and register 5 reads 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone register slave.
// Holds the transfer FSM state encoding, the default ID word and wait-state limits.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wb_state_t;

    localparam logic [31:0] WB_ID_DEFAULT     = 32'h5742_0001;
    localparam int          WB_WAIT_STATES_MAX = 15;
    localparam int          WB_CNT_W           = 4;

endpackage : wb_pkg

// File: rtl/wb_regfile.sv
// Byte-enabled register storage for the Wishbone slave.
// Register 0 is a read-only ID word; registers 1..NUM_REGS-1 are read/write.
module wb_regfile
    import wb_pkg::*;
#(
    parameter int                   REG_WIDTH  = 32,
    parameter int                   ADDR_WIDTH = 5,
    parameter int                   NUM_REGS   = 32,
    parameter logic [REG_WIDTH-1:0] ID_VALUE   = REG_WIDTH'(WB_ID_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [ADDR_WIDTH-1:0]  wr_adr,
    input  logic [REG_WIDTH-1:0]   wr_dat,
    input  logic [REG_WIDTH/8-1:0] wr_sel,
    input  logic [ADDR_WIDTH-1:0]  rd_adr,
    output logic [REG_WIDTH-1:0]   rd_dat
);

    localparam int SEL_W = REG_WIDTH / 8;

    logic [REG_WIDTH-1:0] mem [1:NUM_REGS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_adr == ADDR_WIDTH'(i)) begin
                    for (int b = 0; b < SEL_W; b++) begin
                        if (wr_sel[b]) begin
                            mem[i][b*8 +: 8] <= wr_dat[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Out-of-range addresses read as zero; the slave never forwards them anyway.
    always_comb begin
        rd_dat = '0;
        if (rd_adr == '0) begin
            rd_dat = ID_VALUE;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (rd_adr == ADDR_WIDTH'(i)) begin
                    rd_dat = mem[i];
                end
            end
        end
    end

endmodule : wb_regfile

// File: rtl/wb_reg_slave.sv
// Wishbone classic register slave with configurable wait states.
// One request is captured in IDLE, optionally delayed in WAIT, and answered from RESP.
module wb_reg_slave
    import wb_pkg::*;
#(
    parameter int                   REG_WIDTH   = 32,
    parameter int                   ADDR_WIDTH  = 5,
    parameter int                   NUM_REGS    = 32,
    parameter int                   WAIT_STATES = 0,
    parameter logic [REG_WIDTH-1:0] ID_VALUE    = REG_WIDTH'(WB_ID_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_WIDTH-1:0]  wb_adr_i,
    input  logic [REG_WIDTH-1:0]   wb_dat_i,
    output logic [REG_WIDTH-1:0]   wb_dat_o,
    input  logic [REG_WIDTH/8-1:0] sel_i,
    input  logic                   we_i,
    input  logic                   stb_i,
    input  logic                   cyc_i,
    output logic                   ack_o,
    output logic                   err_o
);

    localparam int SEL_W = REG_WIDTH / 8;
    localparam logic [WB_CNT_W-1:0] CNT_LOAD =
        (WAIT_STATES > 0) ? WB_CNT_W'(WAIT_STATES - 1) : '0;

    wb_state_t             state;
    wb_state_t             state_nxt;
    logic [WB_CNT_W-1:0]   wait_cnt;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [REG_WIDTH-1:0]  dat_q;
    logic [SEL_W-1:0]      sel_q;
    logic                  we_q;
    logic                  accept;
    logic                  adr_err;
    logic                  ack_nxt;
    logic                  err_nxt;
    logic                  wr_en;
    logic [REG_WIDTH-1:0]  rd_dat;
    logic [REG_WIDTH-1:0]  dat_nxt;

    assign accept  = (state == IDLE) && cyc_i && stb_i;
    assign adr_err = (int'(adr_q) >= NUM_REGS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (!cyc_i) begin
                    state_nxt = IDLE;
                end else if (wait_cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The response is decided in RESP and registered, so it appears after the RESP edge.
    always_comb begin
        ack_nxt = (state == RESP) && !adr_err;
        err_nxt = (state == RESP) && adr_err;
        wr_en   = ack_nxt && we_q;
        dat_nxt = (ack_nxt && !we_q) ? rd_dat : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_o    <= 1'b0;
            err_o    <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            ack_o    <= ack_nxt;
            err_o    <= err_nxt;
            wb_dat_o <= dat_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= CNT_LOAD;
        end else if (state == WAIT) begin
            if (!cyc_i) begin
                wait_cnt <= '0;
            end else if (wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q <= '0;
            dat_q <= '0;
            sel_q <= '0;
            we_q  <= 1'b0;
        end else if (accept) begin
            adr_q <= wb_adr_i;
            dat_q <= wb_dat_i;
            sel_q <= sel_i;
            we_q  <= we_i;
        end
    end

    wb_regfile #(
        .REG_WIDTH  (REG_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ID_VALUE   (ID_VALUE)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en),
        .wr_adr (adr_q),
        .wr_dat (dat_q),
        .wr_sel (sel_q),
        .rd_adr (adr_q),
        .rd_dat (rd_dat)
    );

endmodule : wb_reg_slave

// File: tb/tb_wb_reg_slave.sv
// Directed bench for wb_reg_slave: three instances with 0, 3 and 4 wait states.
module tb_wb_reg_slave;

    logic        clk;
    logic        rst_n;
    logic [4:0]  bus_adr [3];
    logic [31:0] bus_wdat[3];
    logic [31:0] bus_rdat[3];
    logic [3:0]  bus_sel [3];
    logic        bus_we  [3];
    logic        bus_stb [3];
    logic        bus_cyc [3];
    logic        bus_ack [3];
    logic        bus_err [3];

    int n_tot = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: no wait states, 16 regs. Instance 1: 3 wait states. Instance 2: 4 wait states.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        wb_reg_slave #(
            .REG_WIDTH   (32),
            .ADDR_WIDTH  (5),
            .NUM_REGS    ((g == 0) ? 16 : 32),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 3 : 4)),
            .ID_VALUE    (32'h5742_0001)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .wb_adr_i (bus_adr[g]),
            .wb_dat_i (bus_wdat[g]),
            .wb_dat_o (bus_rdat[g]),
            .sel_i    (bus_sel[g]),
            .we_i     (bus_we[g]),
            .stb_i    (bus_stb[g]),
            .cyc_i    (bus_cyc[g]),
            .ack_o    (bus_ack[g]),
            .err_o    (bus_err[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic bus_idle(input int d);
        bus_cyc[d]  = 1'b0;
        bus_stb[d]  = 1'b0;
        bus_we[d]   = 1'b0;
        bus_adr[d]  = '0;
        bus_wdat[d] = '0;
        bus_sel[d]  = '0;
    endtask

    task automatic xfer(input int d, input logic w, input logic [4:0] a,
                        input logic [31:0] wd, input logic [3:0] s,
                        output logic [31:0] rd, output int lat,
                        output logic saw_ack, output logic saw_err);
        @(negedge clk);
        bus_cyc[d]  = 1'b1;
        bus_stb[d]  = 1'b1;
        bus_we[d]   = w;
        bus_adr[d]  = a;
        bus_wdat[d] = wd;
        bus_sel[d]  = s;
        @(posedge clk);
        #1;
        lat = 0; saw_ack = 1'b0; saw_err = 1'b0; rd = '0;
        while (!saw_ack && !saw_err && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            saw_ack = bus_ack[d];
            saw_err = bus_err[d];
            rd      = bus_rdat[d];
        end
        chk("ack_err_exclusive", {31'd0, saw_ack & saw_err}, 32'd0);
        bus_idle(d);
        @(posedge clk);
        #1;
        chk("resp_one_cycle", {29'd0, bus_ack[d], bus_err[d], |bus_rdat[d]}, 32'd0);
    endtask

    task automatic wr(input int d, input logic [4:0] a, input logic [31:0] wd,
                      input logic [3:0] s, input int exp_lat, input logic exp_err,
                      input string tag);
        logic [31:0] rd;
        int          lat;
        logic        ak, er;
        xfer(d, 1'b1, a, wd, s, rd, lat, ak, er);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_ack"}, {31'd0, ak}, {31'd0, !exp_err});
        chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    endtask

    task automatic rdchk(input int d, input logic [4:0] a, input logic [31:0] exp_dat,
                         input int exp_lat, input logic exp_err, input string tag);
        logic [31:0] rd;
        int          lat;
        logic        ak, er;
        xfer(d, 1'b0, a, 32'hFFFF_FFFF, 4'h0, rd, lat, ak, er);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
        chk({tag, "_dat"}, rd, exp_dat);
    endtask

    task automatic quiet_window(input int d, input int cycles, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus_ack[d] || bus_err[d]) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        int first_ack;
        int second_ack;

        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) bus_idle(d);
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset_outputs", {bus_rdat[d][30:0], bus_ack[d]}, 32'd0);
            chk("reset_err", {31'd0, bus_err[d]}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Zero wait states: basic write/read and byte lanes.
        wr   (0, 5'd3, 32'hDEAD_BEEF, 4'hF, 1, 1'b0, "w0_a3");
        rdchk(0, 5'd3, 32'hDEAD_BEEF, 1, 1'b0, "r0_a3");
        wr   (0, 5'd5, 32'h1122_3344, 4'hF, 1, 1'b0, "w0_a5_full");
        wr   (0, 5'd5, 32'hAABB_CCDD, 4'b0101, 1, 1'b0, "w0_a5_part");
        rdchk(0, 5'd5, 32'h11BB_33DD, 1, 1'b0, "r0_a5");
        wr   (0, 5'd3, 32'h0000_0000, 4'h0, 1, 1'b0, "w0_sel0");
        rdchk(0, 5'd3, 32'hDEAD_BEEF, 1, 1'b0, "r0_sel0");
        rdchk(0, 5'd1, 32'h0000_0000, 1, 1'b0, "r0_a1_reset");
        rdchk(0, 5'd15, 32'h0000_0000, 1, 1'b0, "r0_a15");

        // Out-of-range on the 16-register instance.
        wr   (0, 5'd20, 32'h0BAD_F00D, 4'hF, 1, 1'b1, "w0_a20");
        wr   (0, 5'd16, 32'h0BAD_F00D, 4'hF, 1, 1'b1, "w0_a16");
        rdchk(0, 5'd20, 32'h0000_0000, 1, 1'b1, "r0_a20");
        rdchk(0, 5'd3, 32'hDEAD_BEEF, 1, 1'b0, "r0_a3_after_err");
        rdchk(0, 5'd4, 32'h0000_0000, 1, 1'b0, "r0_a4_after_err");

        // Three wait states: ID register behaviour and latency.
        rdchk(1, 5'd0, 32'h5742_0001, 4, 1'b0, "r1_id");
        wr   (1, 5'd0, 32'h0000_0000, 4'hF, 4, 1'b0, "w1_id");
        rdchk(1, 5'd0, 32'h5742_0001, 4, 1'b0, "r1_id_again");
        wr   (1, 5'd31, 32'hCAFE_0031, 4'b1000, 4, 1'b0, "w1_a31");
        rdchk(1, 5'd31, 32'hCA00_0000, 4, 1'b0, "r1_a31");

        // Held strobe: back-to-back reads every 2+3 cycles.
        @(negedge clk);
        bus_cyc[1] = 1'b1; bus_stb[1] = 1'b1; bus_we[1] = 1'b0;
        bus_adr[1] = 5'd0; bus_sel[1] = 4'hF;
        @(posedge clk);
        first_ack = -1; second_ack = -1;
        for (int i = 1; i <= 11; i++) begin
            @(posedge clk);
            #1;
            if (bus_ack[1]) begin
                if (first_ack < 0) first_ack = i;
                else if (second_ack < 0) second_ack = i;
            end
        end
        bus_idle(1);
        chk("b2b_first", 32'(first_ack), 32'd4);
        chk("b2b_second", 32'(second_ack), 32'd9);
        quiet_window(1, 8, "b2b_abort_quiet");

        // Four wait states: abort by dropping cyc in WAIT.
        wr   (2, 5'd5, 32'h0000_0055, 4'hF, 5, 1'b0, "w2_a5");
        @(negedge clk);
        bus_cyc[2] = 1'b1; bus_stb[2] = 1'b1; bus_we[2] = 1'b1;
        bus_adr[2] = 5'd5; bus_wdat[2] = 32'hFFFF_FFFF; bus_sel[2] = 4'hF;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        bus_idle(2);
        quiet_window(2, 10, "abort_no_resp");
        rdchk(2, 5'd5, 32'h0000_0055, 5, 1'b0, "r2_after_abort");

        // Reset pulse in the middle of a waited write.
        @(negedge clk);
        bus_cyc[2] = 1'b1; bus_stb[2] = 1'b1; bus_we[2] = 1'b1;
        bus_adr[2] = 5'd5; bus_wdat[2] = 32'h1234_5678; bus_sel[2] = 4'hF;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_mid_ack_err", {30'd0, bus_ack[d], bus_err[d]}, 32'd0);
            chk("rst_mid_dat", bus_rdat[d], 32'd0);
        end
        bus_idle(2);
        #5;
        rst_n = 1'b1;
        quiet_window(2, 10, "rst_no_resp");
        rdchk(2, 5'd5, 32'h0000_0000, 5, 1'b0, "r2_a5_after_rst");
        rdchk(0, 5'd3, 32'h0000_0000, 1, 1'b0, "r0_a3_after_rst");
        rdchk(1, 5'd0, 32'h5742_0001, 4, 1'b0, "r1_id_after_rst");

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_wb_reg_slave
